atuador_dampers: RTL

//  Downstream of the ventilation control logic: turns its per-damper open/close commands and the

---
 rtl/atuador_dampers.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/atuador_dampers.sv
// Damper actuator: per-damper travel FSMs with limit-switch supervision and timeout,
// plus the latched horn/lamp driven by the ventilation alarm and damper faults.
module atuador_dampers #(
    parameter int NUM_DAMPERS    = 7,
    parameter int TEMPO_CURSO    = 16,
    parameter int PAUSA_REVERSAO = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_DAMPERS-1:0] cmdDamper,
    input  logic                   alarmeVentilacao,
    input  logic                   reconhecer,
    input  logic [NUM_DAMPERS-1:0] fimAberto,
    input  logic [NUM_DAMPERS-1:0] fimFechado,
    output logic [NUM_DAMPERS-1:0] motorAbrir,
    output logic [NUM_DAMPERS-1:0] motorFechar,
    output logic [NUM_DAMPERS-1:0] posicaoAberta,
    output logic [NUM_DAMPERS-1:0] falhaDamper,
    output logic                   alarmeSonoro,
    output logic                   alarmeVisual
);

    localparam int MAX_CONTA = (TEMPO_CURSO > PAUSA_REVERSAO) ? TEMPO_CURSO : PAUSA_REVERSAO;
    localparam int CW        = $clog2(MAX_CONTA + 1);
    localparam logic [CW-1:0] C_CURSO_FIM = CW'(TEMPO_CURSO - 1);
    localparam logic [CW-1:0] C_PAUSA_FIM = CW'(PAUSA_REVERSAO - 1);

    typedef enum logic [2:0] {
        FECHADO  = 3'd0,
        ABRINDO  = 3'd1,
        ABERTO   = 3'd2,
        FECHANDO = 3'd3,
        PAUSA    = 3'd4,
        FALHA    = 3'd5
    } estado_t;

    logic [NUM_DAMPERS-1:0] r_ab_s1, r_ab_s2, r_fe_s1, r_fe_s2;
    logic [NUM_DAMPERS-1:0] w_motor_abrir, w_motor_fechar, w_aberta, w_falha;
    logic [NUM_DAMPERS-1:0] r_falha_prev;
    logic                   r_vent_prev;
    logic                   r_sonoro, r_visual;
    logic                   w_causa, w_set_sonoro;

    // Field switches are asynchronous; the FSMs only ever look at the second stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ab_s1 <= '0;
            r_ab_s2 <= '0;
            r_fe_s1 <= '0;
            r_fe_s2 <= '0;
        end else begin
            r_ab_s1 <= fimAberto;
            r_ab_s2 <= r_ab_s1;
            r_fe_s1 <= fimFechado;
            r_fe_s2 <= r_fe_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DAMPERS; gi++) begin : g_damper
            estado_t       r_estado, w_proximo;
            logic [CW-1:0] r_cnt;
            logic          w_conta;

            assign w_conta = (r_estado == PAUSA) || (r_estado == ABRINDO) || (r_estado == FECHANDO);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_estado <= PAUSA;
                    r_cnt    <= '0;
                end else begin
                    r_estado <= w_proximo;
                    if (w_proximo != r_estado)
                        r_cnt <= '0;
                    else if (w_conta)
                        r_cnt <= r_cnt + CW'(1);
                end
            end

            always_comb begin
                w_proximo = r_estado;
                case (r_estado)
                    FECHADO:  if (cmdDamper[gi]) w_proximo = PAUSA;
                    ABRINDO: begin
                        if (r_ab_s2[gi])               w_proximo = ABERTO;
                        else if (!cmdDamper[gi])       w_proximo = PAUSA;
                        else if (r_cnt == C_CURSO_FIM) w_proximo = FALHA;
                    end
                    ABERTO:   if (!cmdDamper[gi]) w_proximo = PAUSA;
                    FECHANDO: begin
                        if (r_fe_s2[gi])               w_proximo = FECHADO;
                        else if (cmdDamper[gi])        w_proximo = PAUSA;
                        else if (r_cnt == C_CURSO_FIM) w_proximo = FALHA;
                    end
                    PAUSA:    if (r_cnt == C_PAUSA_FIM) w_proximo = cmdDamper[gi] ? ABRINDO : FECHANDO;
                    FALHA:    if (reconhecer) w_proximo = PAUSA;
                    default:  w_proximo = PAUSA;
                endcase
                // Both switches made means broken wiring or a stuck switch: trust neither.
                if (r_ab_s2[gi] && r_fe_s2[gi] && (r_estado != FALHA))
                    w_proximo = FALHA;
            end

            assign w_motor_abrir[gi]  = (r_estado == ABRINDO);
            assign w_motor_fechar[gi] = (r_estado == FECHANDO);
            assign w_aberta[gi]       = (r_estado == ABERTO);
            assign w_falha[gi]        = (r_estado == FALHA);
        end
    endgenerate

    assign w_causa      = alarmeVentilacao | (|w_falha);
    assign w_set_sonoro = (alarmeVentilacao & ~r_vent_prev) | (|(w_falha & ~r_falha_prev));

    // A new event outranks a same-cycle acknowledge, so no alarm is silently lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vent_prev  <= 1'b0;
            r_falha_prev <= '0;
            r_sonoro     <= 1'b0;
            r_visual     <= 1'b0;
        end else begin
            r_vent_prev  <= alarmeVentilacao;
            r_falha_prev <= w_falha;
            if (w_set_sonoro)
                r_sonoro <= 1'b1;
            else if (reconhecer)
                r_sonoro <= 1'b0;
            if (w_causa)
                r_visual <= 1'b1;
            else if (reconhecer)
                r_visual <= 1'b0;
        end
    end

    assign motorAbrir    = w_motor_abrir;
    assign motorFechar   = w_motor_fechar;
    assign posicaoAberta = w_aberta;
    assign falhaDamper   = w_falha;
    assign alarmeSonoro  = r_sonoro;
    assign alarmeVisual  = r_visual;

endmodule
